// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the RV32M iterative multiply/divide unit: M-op funct3 codes,
// FSM state encoding, iteration constants and the sign fix-up helpers used at completion.
package mul_div_unit_pkg;

  localparam int unsigned Xlen    = 32;
  localparam int unsigned CntW    = 5;
  localparam int unsigned MduIter = 32;

  localparam logic [CntW-1:0] CntLast = CntW'(MduIter - 1);

  localparam logic [2:0] F3Mul    = 3'b000;
  localparam logic [2:0] F3Mulh   = 3'b001;
  localparam logic [2:0] F3Mulhsu = 3'b010;
  localparam logic [2:0] F3Mulhu  = 3'b011;
  localparam logic [2:0] F3Div    = 3'b100;
  localparam logic [2:0] F3Divu   = 3'b101;
  localparam logic [2:0] F3Rem    = 3'b110;
  localparam logic [2:0] F3Remu   = 3'b111;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFin} mdu_state_e;

  // Conditional two's complement.
  function automatic logic [Xlen-1:0] cond_neg32(logic [Xlen-1:0] v, logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*Xlen-1:0] cond_neg64(logic [2*Xlen-1:0] v, logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  // Product magnitude sits in acc; MUL takes the low word, MULH* the high word.
  function automatic logic [Xlen-1:0] mul_fix(logic [2*Xlen-1:0] acc, logic neg, logic [2:0] op);
    logic [2*Xlen-1:0] prod;
    prod = cond_neg64(acc, neg);
    return (op == F3Mul) ? prod[Xlen-1:0] : prod[2*Xlen-1:Xlen];
  endfunction

  // acc holds {remainder, quotient} magnitudes; remainder follows the dividend sign.
  function automatic logic [Xlen-1:0] div_fix(logic [2*Xlen-1:0] acc, logic neg, logic rneg,
                                              logic [2:0] op);
    return op[1] ? cond_neg32(acc[2*Xlen-1:Xlen], rneg) : cond_neg32(acc[Xlen-1:0], neg);
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative RV32M execution unit: radix-2 shift-add multiply and restoring divide, one
// iteration per cycle over a shared 64-bit shift register, with a one-cycle fast path for
// divide-by-zero and signed overflow.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   start_i, abort_i     request (accepted in idle only) and pipeline flush (wins over start)
//   func3_i, rs1_i, rs2_i  M-op select and operands, sampled only at accept
//   busy_o               high whenever not idle
//   done_o               one-cycle completion pulse, result_o valid in that cycle
//   result_o             result, held until the next completed operation
module mul_div_unit
  import mul_div_unit_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [2:0]      func3_i,
  input  logic [Xlen-1:0] rs1_i,
  input  logic [Xlen-1:0] rs2_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [Xlen-1:0] result_o
);

  mdu_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic              rneg_q, rneg_d;
  logic [2*Xlen-1:0] acc_q, acc_d;
  logic [Xlen-1:0]   b_q, b_d;
  logic [Xlen-1:0]   result_q, result_d;
  logic              done_q, done_d;

  logic            a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
  logic [Xlen-1:0] a_mag, b_mag;
  logic [Xlen:0]   mul_sum, div_pr, div_diff;

  // Operand decode at accept time.
  always_comb begin
    a_signed = (func3_i == F3Mulh) || (func3_i == F3Mulhsu) ||
               (func3_i == F3Div)  || (func3_i == F3Rem);
    b_signed = (func3_i == F3Mulh) || (func3_i == F3Div) || (func3_i == F3Rem);
    a_neg    = a_signed & rs1_i[Xlen-1];
    b_neg    = b_signed & rs2_i[Xlen-1];
    // 0x80000000 negates to itself, which is the correct unsigned magnitude.
    a_mag    = cond_neg32(rs1_i, a_neg);
    b_mag    = cond_neg32(rs2_i, b_neg);
    div_zero = (rs2_i == '0);
    div_ovf  = ((func3_i == F3Div) || (func3_i == F3Rem)) &&
               (rs1_i == 32'h8000_0000) && (rs2_i == 32'hFFFF_FFFF);
  end

  // One datapath step for each algorithm.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*Xlen-1:Xlen]} + (acc_q[0] ? {1'b0, b_q} : '0);
    // 33-bit partial remainder: previous remainder shifted left with the next dividend bit.
    div_pr   = acc_q[2*Xlen-1:Xlen-1];
    div_diff = div_pr - {1'b0, b_q};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    acc_d    = acc_q;
    b_d      = b_q;
    result_d = result_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i && !abort_i) begin
          op_d   = func3_i;
          neg_d  = a_neg ^ b_neg;
          rneg_d = a_neg;
          b_d    = b_mag;
          acc_d  = {{Xlen{1'b0}}, a_mag};
          cnt_d  = '0;
          if (!func3_i[2]) begin
            state_d = StMul;
          end else if (div_zero) begin
            state_d  = StFin;
            result_d = func3_i[1] ? rs1_i : '1;
            done_d   = 1'b1;
          end else if (div_ovf) begin
            state_d  = StFin;
            result_d = func3_i[1] ? '0 : 32'h8000_0000;
            done_d   = 1'b1;
          end else begin
            state_d = StDiv;
          end
        end
      end
      StMul: begin
        if (abort_i) begin
          state_d = StIdle;
        end else begin
          acc_d = {mul_sum, acc_q[Xlen-1:1]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            state_d  = StFin;
            result_d = mul_fix(acc_d, neg_q, op_q);
            done_d   = 1'b1;
          end
        end
      end
      StDiv: begin
        if (abort_i) begin
          state_d = StIdle;
        end else begin
          if (!div_diff[Xlen]) begin
            acc_d = {div_diff[Xlen-1:0], acc_q[Xlen-2:0], 1'b1};
          end else begin
            acc_d = {div_pr[Xlen-1:0], acc_q[Xlen-2:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            state_d  = StFin;
            result_d = div_fix(acc_d, neg_q, rneg_q, op_q);
            done_d   = 1'b1;
          end
        end
      end
      // Result and done are registered on entry, so this cycle only retires.
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      acc_q    <= '0;
      b_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign busy_o   = (state_q != StIdle);
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus randomized operations
// compared against a plain-arithmetic RV32M reference model.
module tb_mul_div_unit;

  logic        clk, rst_ni, start, abort, busy, done;
  logic [2:0]  func3;
  logic [31:0] rs1, rs2, result;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;

  mul_div_unit u_dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .start_i (start),
    .abort_i (abort),
    .func3_i (func3),
    .rs1_i   (rs1),
    .rs2_i   (rs2),
    .busy_o  (busy),
    .done_o  (done),
    .result_o(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model straight from the RV32M definitions.
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    int          ia, ib;
    longint      la, lb, lbu, p;
    logic [63:0] pu, pv;
    ia = a; ib = b;
    la = ia; lb = ib;
    lbu = {32'd0, b};
    case (f3)
      3'b000: begin pu = {32'd0, a} * {32'd0, b}; return pu[31:0]; end
      3'b001: begin p = la * lb;  pv = p; return pv[63:32]; end
      3'b010: begin p = la * lbu; pv = p; return pv[63:32]; end
      3'b011: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = la / lb; pv = p; return pv[31:0];
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        p = la % lb; pv = p; return pv[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b);
    if (f3[2] && b == 0) return 1;
    if ((f3 == 3'b100 || f3 == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Accept at the edge ending cycle T; returns at T+1 with inputs scrambled.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    func3 = f3; rs1 = a; rs2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; rs1 = $urandom; rs2 = $urandom; func3 = 3'($urandom);
  endtask

  // Called in cycle T+t0; returns lat (0 on timeout) and leaves the DUT idle.
  task automatic wait_done(input int t0, output logic [31:0] res, output int lat);
    lat = 0; res = 'x;
    for (int i = t0; i <= t0 + 60; i++) begin
      if (done === 1'b1) begin lat = i; res = result; break; end
      @(posedge clk); #1;
    end
    if (lat != 0) begin
      check("busy_in_fin", busy, 1);
      @(posedge clk); #1;
      check("busy_after_fin", busy, 0);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] exp);
    logic [31:0] res;
    int          lat;
    exp = ref_model(f3, a, b);
    issue(f3, a, b);
    check({tag, "_busy"}, busy, (ref_lat(f3, a, b) == 1) ? 1'b1 : 1'b1);
    wait_done(1, res, lat);
    check({tag, "_lat"}, 64'(lat), 64'(ref_lat(f3, a, b)));
    check({tag, "_res"}, res, exp);
  endtask

  initial begin
    logic [31:0] exp_last, r;
    int          dc0, lat;

    rst_ni = 1'b0; start = 1'b0; abort = 1'b0; func3 = '0; rs1 = '0; rs2 = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    @(negedge clk); rst_ni = 1'b1;

    run_op("mul_7x6",    3'b000, 32'd7, 32'd6, exp_last);
    run_op("mulh_m1",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, exp_last);
    run_op("mulhu_m1",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, exp_last);
    run_op("mulhsu_m1",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, exp_last);
    run_op("div_m7_2",   3'b100, 32'hFFFF_FFF9, 32'd2, exp_last);
    run_op("rem_m7_2",   3'b110, 32'hFFFF_FFF9, 32'd2, exp_last);
    run_op("divu_100_7", 3'b101, 32'd100, 32'd7, exp_last);
    run_op("remu_100_7", 3'b111, 32'd100, 32'd7, exp_last);
    run_op("divu_by0",   3'b101, 32'h1234, 32'd0, exp_last);
    run_op("rem_by0",    3'b110, 32'h1234, 32'd0, exp_last);
    run_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, exp_last);
    run_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, exp_last);

    // abort at T+10: idle at T+11, no done, result untouched
    dc0 = done_cnt;
    issue(3'b100, 32'd1000, 32'd3);
    repeat (9) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_idle", busy, 0);
    repeat (40) begin @(posedge clk); #1; end
    check("abort_no_done", 64'(done_cnt - dc0), 0);
    check("abort_result", result, exp_last);

    // abort together with start in idle: abort wins
    @(negedge clk); start = 1'b1; abort = 1'b1; func3 = 3'b000;
    @(posedge clk); #1; start = 1'b0; abort = 1'b0;
    check("abort_beats_start", busy, 0);

    // second start at T+5 is ignored
    dc0 = done_cnt;
    exp_last = ref_model(3'b000, 32'hDEAD_BEEF, 32'h1357_9BDF);
    issue(3'b000, 32'hDEAD_BEEF, 32'h1357_9BDF);
    repeat (4) begin @(posedge clk); #1; end
    start = 1'b1; func3 = 3'b101; rs2 = 32'd0;
    @(posedge clk); #1; start = 1'b0;
    wait_done(6, r, lat);
    check("ignore_lat", 64'(lat), 33);
    check("ignore_res", r, exp_last);
    repeat (5) begin @(posedge clk); #1; end
    check("ignore_one_done", 64'(done_cnt - dc0), 1);

    // start held high through a fast-path FIN is re-sampled only once idle
    @(negedge clk); start = 1'b1; func3 = 3'b101; rs1 = 32'h55; rs2 = 32'd0;
    @(posedge clk); #1;
    check("hold_t1_done", done, 1);
    @(posedge clk); #1;
    check("hold_t2_done", done, 0);
    check("hold_t2_busy", busy, 0);
    @(posedge clk); #1;
    check("hold_t3_done", done, 1);
    start = 1'b0;
    @(posedge clk); #1;
    check("hold_t4_busy", busy, 0);
    exp_last = 32'hFFFF_FFFF;

    // asynchronous reset mid-multiply
    issue(3'b000, 32'd12345, 32'd678);
    repeat (14) begin @(posedge clk); #1; end
    #2 rst_ni = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_result", result, 0);
    @(negedge clk); rst_ni = 1'b1;
    run_op("mul_3x5", 3'b000, 32'd3, 32'd5, exp_last);

    for (int n = 0; n < 40; n++) begin
      run_op("rand", 3'($urandom_range(0, 7)), pick(), pick(), exp_last);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
